// File: rtl/ysyx_040750_pkg.sv
// Shared encodings for the ysyx_040750 core: GPR write-source select, load strobes, csr_ctl layout.
package ysyx_040750_pkg;

  localparam logic [1:0] REGIN_ALU = 2'b00;
  localparam logic [1:0] REGIN_CSR = 2'b01;
  localparam logic [1:0] REGIN_MEM = 2'b10;

  localparam logic [7:0] RSTRB_B = 8'h01;
  localparam logic [7:0] RSTRB_H = 8'h03;
  localparam logic [7:0] RSTRB_W = 8'h0F;
  localparam logic [7:0] RSTRB_D = 8'hFF;
  localparam int         RSTRB_ZEXT_BIT = 8;

  // csr_ctl = {intr_no[63:0], csr_addr[11:0], csr_wen, csr_intr, csr_mret}
  localparam int CSR_CTL_W       = 79;
  localparam int CSR_MRET_BIT    = 0;
  localparam int CSR_INTR_BIT    = 1;
  localparam int CSR_WEN_BIT     = 2;
  localparam int CSR_ADDR_LSB    = 3;
  localparam int CSR_INTR_NO_LSB = 15;

endpackage

// File: rtl/ysyx_040750_load_align.sv
// Combinational load aligner: shifts raw 8-byte data by the byte offset, then masks and extends.
// Misaligned accesses use the shifted bytes as-is; alignment faults are raised upstream.
module ysyx_040750_load_align
  import ysyx_040750_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  logic [8:0]      rstrb_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sh;
  logic            zext;

  always_comb begin
    sh     = rdata_i >> {offset_i, 3'b000};
    zext   = rstrb_i[RSTRB_ZEXT_BIT];
    data_o = sh;
    case (rstrb_i[7:0])
      RSTRB_B: data_o = {{(XLEN-8){~zext & sh[7]}},   sh[7:0]};
      RSTRB_H: data_o = {{(XLEN-16){~zext & sh[15]}}, sh[15:0]};
      RSTRB_W: data_o = {{(XLEN-32){~zext & sh[31]}}, sh[31:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/ysyx_040750_mem_wb_stage.sv
// MEM->WB pipeline register: aligns load data, registers the GPR write value, commits GPR/CSR/fence.i.
// Latency 1 cycle; holds while I_WB_allowout=0. YSYX_040750_WB_TRACE_EN adds O_trace_pc/O_trace_wdata.
module ysyx_040750_mem_wb_stage
  import ysyx_040750_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic                 I_sys_clk,
  input  logic                 I_rst_n,
  input  logic                 I_MEM_WB_valid,
  output logic                 O_MEM_WB_allowin,
  input  logic                 I_WB_allowout,
  input  logic                 I_flush,
  input  logic [PC_W-1:0]      I_pc,
  input  logic                 I_reg_wen,
  input  logic [4:0]           I_rd_addr,
  input  logic [1:0]           I_regin_sel,
  input  logic [8:0]           I_rstrb,
  input  logic [XLEN-1:0]      I_alu_out,
  input  logic [XLEN-1:0]      I_mem_rdata,
  input  logic [XLEN-1:0]      I_csr,
  input  logic [CSR_CTL_W-1:0] I_csr_ctl,
  input  logic                 I_fencei,
  output logic                 O_valid,
  output logic                 O_commit,
  output logic [PC_W-1:0]      O_pc,
  output logic                 O_reg_wen,
  output logic [4:0]           O_rd_addr,
  output logic [XLEN-1:0]      O_rd_data,
  output logic [CSR_CTL_W-1:0] O_csr_ctl,
  output logic [XLEN-1:0]      O_csr_wdata,
  output logic                 O_fencei,
  output logic                 O_fwd_valid,
  output logic [4:0]           O_fwd_rd,
  output logic [XLEN-1:0]      O_fwd_data
`ifdef YSYX_040750_WB_TRACE_EN
  ,
  output logic [PC_W-1:0]      O_trace_pc,
  output logic [XLEN-1:0]      O_trace_wdata
`endif
);

  logic                 valid_q, valid_d;
  logic [PC_W-1:0]      pc_q;
  logic                 reg_wen_q;
  logic [4:0]           rd_q;
  logic [XLEN-1:0]      rd_data_q, rd_data_d;
  logic [CSR_CTL_W-1:0] csr_ctl_q;
  logic [XLEN-1:0]      csr_wdata_q;
  logic                 fencei_q;

  logic [XLEN-1:0]      load_data;
  logic                 commit;
  logic                 accept;
  logic                 rd_live;

  ysyx_040750_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (I_mem_rdata),
    .offset_i (I_alu_out[2:0]),
    .rstrb_i  (I_rstrb),
    .data_o   (load_data)
  );

  always_comb begin
    rd_data_d = I_regin_sel[1] ? load_data :
                I_regin_sel[0] ? I_csr     : I_alu_out;
  end

  assign commit  = valid_q & I_WB_allowout & ~I_flush;
  assign accept  = I_MEM_WB_valid & O_MEM_WB_allowin & ~I_flush;
  assign rd_live = reg_wen_q & (rd_q != 5'd0);

  // Flush wins over both accept and commit; held fields are left untouched on flush.
  always_comb begin
    valid_d = valid_q;
    if (I_flush)     valid_d = 1'b0;
    else if (accept) valid_d = 1'b1;
    else if (commit) valid_d = 1'b0;
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      reg_wen_q   <= 1'b0;
      rd_q        <= '0;
      rd_data_q   <= '0;
      csr_ctl_q   <= '0;
      csr_wdata_q <= '0;
      fencei_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q        <= I_pc;
        reg_wen_q   <= I_reg_wen;
        rd_q        <= I_rd_addr;
        rd_data_q   <= rd_data_d;
        csr_ctl_q   <= I_csr_ctl;
        csr_wdata_q <= I_alu_out;
        fencei_q    <= I_fencei;
      end
    end
  end

  assign O_MEM_WB_allowin = ~valid_q | commit;
  assign O_valid          = valid_q;
  assign O_commit         = commit;
  assign O_pc             = pc_q;
  assign O_reg_wen        = commit & rd_live;
  assign O_rd_addr        = rd_q;
  assign O_rd_data        = rd_data_q;
  assign O_csr_wdata      = csr_wdata_q;
  assign O_fencei         = commit & fencei_q;

  // Only the three strobe bits are gated; address and interrupt number stay visible while held.
  always_comb begin
    O_csr_ctl               = csr_ctl_q;
    O_csr_ctl[CSR_WEN_BIT]  = csr_ctl_q[CSR_WEN_BIT]  & commit;
    O_csr_ctl[CSR_INTR_BIT] = csr_ctl_q[CSR_INTR_BIT] & commit;
    O_csr_ctl[CSR_MRET_BIT] = csr_ctl_q[CSR_MRET_BIT] & commit;
  end

  assign O_fwd_valid = valid_q & rd_live;
  assign O_fwd_rd    = rd_q;
  assign O_fwd_data  = rd_data_q;

`ifdef YSYX_040750_WB_TRACE_EN
  assign O_trace_pc    = commit ? pc_q      : '0;
  assign O_trace_wdata = commit ? rd_data_q : '0;
`endif

endmodule
